// File: rtl/apb_pkg.sv
// Shared types for the APB command master: FSM state encoding and
// command/response records at the default bus widths.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_cmd_master.sv
// APB3 initiator: valid/ready command stream in, registered APB transfer out,
// read data/error on a response stream. Optional ACCESS timeout: APB_TIMEOUT_EN.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              apb_psel,
  output logic              apb_penable,
  output logic              apb_pwrite,
  output logic [ADDR_W-1:0] apb_paddr,
  output logic [DATA_W-1:0] apb_pwdata,
  input  logic [DATA_W-1:0] apb_prdata,
  input  logic              apb_pready,
  input  logic              apb_pslverr
);

  apb_state_e state_q, state_d;
  logic       accept;
  logic       timeout_hit;

  // cmd_ready is a flop, so the first cycle after reset is IDLE but not yet ready
  assign accept = (state_q == IDLE) && cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt_q;

  // Fires on the TIMEOUT_CYC-th waited ACCESS cycle; a same-cycle pready wins
  assign timeout_hit = (state_q == ACCESS) && !apb_pready &&
                       (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      to_cnt_q <= '0;
    end else if ((state_q == ACCESS) && !apb_pready) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout_hit        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (apb_pready || timeout_hit) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready   <= 1'b0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_paddr   <= '0;
      apb_pwdata  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            apb_psel   <= 1'b1;
            apb_pwrite <= cmd_write;
            apb_paddr  <= cmd_addr;
            apb_pwdata <= cmd_write ? cmd_wdata : '0;
          end
        end
        SETUP: begin
          apb_penable <= 1'b1;
        end
        ACCESS: begin
          if (apb_pready || timeout_hit) begin
            apb_psel    <= 1'b0;
            apb_penable <= 1'b0;
            apb_pwrite  <= 1'b0;
            apb_paddr   <= '0;
            apb_pwdata  <= '0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= (apb_pready && !apb_pwrite) ? apb_prdata : '0;
            rsp_err     <= apb_pready ? apb_pslverr : 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: transaction-level model checked
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_apb_cmd_master;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          apb_psel, apb_penable, apb_pwrite;
  logic [AW-1:0] apb_paddr;
  logic [DW-1:0] apb_pwdata, apb_prdata;
  logic          apb_pready, apb_pslverr;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: one in-flight command, one pending response.
  bit            m_rdy, m_busy, m_acc, m_rsp, m_w, m_err;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_wd, m_rd;
  int unsigned   m_waits;

  always @(negedge clk) begin : model
    bit e_rdy;
    if (rst) begin
      m_rdy = 0; m_busy = 0; m_acc = 0; m_rsp = 0; m_w = 0; m_err = 0;
      m_a = '0; m_wd = '0; m_rd = '0; m_waits = 0;
    end
    e_rdy = m_rdy && !m_busy && !m_rsp;
    chk("cmd_ready",   32'(cmd_ready),   32'(e_rdy));
    chk("apb_psel",    32'(apb_psel),    32'(m_busy));
    chk("apb_penable", 32'(apb_penable), 32'(m_acc));
    chk("apb_pwrite",  32'(apb_pwrite),  32'(m_busy && m_w));
    chk("apb_paddr",   32'(apb_paddr),   m_busy ? 32'(m_a) : 32'd0);
    chk("apb_pwdata",  apb_pwdata,       m_busy ? m_wd : 32'd0);
    chk("rsp_valid",   32'(rsp_valid),   32'(m_rsp));
    chk("rsp_rdata",   rsp_rdata,        m_rd);
    chk("rsp_err",     32'(rsp_err),     32'(m_err));
    if (!rst) begin
      if (m_rsp) begin
        if (rsp_ready) begin m_rsp = 0; m_rd = '0; m_err = 0; end
      end else if (m_busy) begin
        if (!m_acc) begin
          m_acc = 1; m_waits = 0;
        end else if (apb_pready) begin
          m_busy = 0; m_acc = 0; m_rsp = 1;
          m_rd = m_w ? '0 : apb_prdata; m_err = apb_pslverr;
        end else begin
          m_waits++;
          if (TO_EN && m_waits >= TO) begin
            m_busy = 0; m_acc = 0; m_rsp = 1; m_rd = '0; m_err = 1;
          end
        end
      end else if (e_rdy && cmd_valid) begin
        m_busy = 1; m_acc = 0; m_w = cmd_write; m_a = cmd_addr;
        m_wd = cmd_write ? cmd_wdata : '0;
      end
      m_rdy = 1;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [DW-1:0] uregs [32];

  task automatic xfer(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input bit err, input logic [DW-1:0] rd,
                      output logic [DW-1:0] got_rd, output logic got_err);
    int g;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    apb_pready = 0; apb_pslverr = 0; rsp_ready = 0;
    g = 0;
    while (!cmd_ready && g < 20) begin cyc(); g++; end
    chk("xfer_cmd_ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 0;
    cyc();
    repeat (waits) cyc();
    apb_pready = 1; apb_prdata = rd; apb_pslverr = err;
    cyc();
    chk("xfer_rsp_valid", 32'(rsp_valid), 32'd1);
    got_rd = rsp_rdata; got_err = rsp_err;
    apb_pready = 0; apb_pslverr = 0; rsp_ready = 1;
    cyc();
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] got_rd;
    logic          got_err;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; apb_prdata = '0; apb_pready = 0; apb_pslverr = 0;
    #1;
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reset_psel", 32'(apb_psel), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 0;
    chk("post_release_not_ready", 32'(cmd_ready), 32'd0);
    cyc(); cyc();
    chk("idle_ready", 32'(cmd_ready), 32'd1);

    // Write, zero wait states
    cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h18; cmd_wdata = 32'h0000_0363;
    apb_pready = 1; apb_prdata = 32'hDEAD_BEEF; apb_pslverr = 0; rsp_ready = 1;
    cyc();
    cmd_valid = 0;
    chk("wr_psel_t1", 32'(apb_psel), 32'd1);
    chk("wr_penable_t1", 32'(apb_penable), 32'd0);
    cyc();
    chk("wr_penable_t2", 32'(apb_penable), 32'd1);
    chk("wr_paddr", 32'(apb_paddr), 32'h18);
    chk("wr_pwdata", apb_pwdata, 32'h363);
    chk("wr_pwrite", 32'(apb_pwrite), 32'd1);
    cyc();
    chk("wr_rsp_valid_t3", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err", 32'(rsp_err), 32'd0);
    chk("wr_rsp_rdata", rsp_rdata, 32'd0);
    chk("wr_psel_clear", 32'(apb_psel), 32'd0);
    cyc();
    chk("wr_back_idle", 32'(cmd_ready), 32'd1);

    // Read with three wait states
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h14; cmd_wdata = 32'hFFFF_FFFF;
    apb_pready = 0;
    cyc();
    cmd_valid = 0;
    chk("rd_pwdata_zero", apb_pwdata, 32'd0);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("rd_penable_held", 32'(apb_penable), 32'd1);
      chk("rd_paddr_stable", 32'(apb_paddr), 32'h14);
      apb_pready = (k == 3);
      apb_prdata = (k == 3) ? 32'h3 : 32'hBAD0_0000;
      cyc();
    end
    chk("rd_penable_drop", 32'(apb_penable), 32'd0);
    chk("rd_rsp_rdata", rsp_rdata, 32'h3);
    cyc();

    // Slave error with response backpressure and a competing command
    rsp_ready = 0; cmd_valid = 1; cmd_write = 1; cmd_addr = 5'h0C; cmd_wdata = 32'h1;
    apb_pready = 1; apb_pslverr = 1;
    cyc();
    cmd_addr = 5'h1F;
    cyc(); cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_err", 32'(rsp_err), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_no_psel", 32'(apb_psel), 32'd0);
      cyc();
    end
    rsp_ready = 1; cmd_valid = 0; apb_pslverr = 0;
    cyc();
    chk("bp_released", 32'(rsp_valid), 32'd0);
    chk("bp_ready_again", 32'(cmd_ready), 32'd1);

    // Reset during ACCESS
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h10; apb_pready = 0;
    cyc();
    cmd_valid = 0;
    cyc();
    chk("rst_pre_penable", 32'(apb_penable), 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_psel", 32'(apb_psel), 32'd0);
    chk("rst_penable", 32'(apb_penable), 32'd0);
    chk("rst_paddr", 32'(apb_paddr), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    cyc();
    rst = 0; apb_pready = 1;
    repeat (3) begin
      cyc();
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    // UART-style register setup, then status and readback through a register-file responder
    for (int i = 0; i < 32; i++) uregs[i] = '0;
    uregs[4] = 32'h0000_0001;
    begin
      logic [AW-1:0] wa [4];
      logic [DW-1:0] wv [4];
      wa = '{5'h08, 5'h0C, 5'h10, 5'h18};
      wv = '{32'h0000_0083, 32'h0000_001B, 32'h0000_0000, 32'h0000_0363};
      for (int i = 0; i < 4; i++) begin
        uregs[wa[i]] = wv[i];
        xfer(1, wa[i], wv[i], i, 0, 32'hFFFF_FFFF, got_rd, got_err);
        chk("uart_wr_rdata", got_rd, 32'd0);
        chk("uart_wr_err", 32'(got_err), 32'd0);
      end
    end
    xfer(0, 5'h04, 32'd0, 1, 0, uregs[4], got_rd, got_err);
    chk("uart_rx_empty", got_rd & 32'h1, 32'h1);
    xfer(0, 5'h18, 32'd0, 0, 0, uregs[24], got_rd, got_err);
    chk("uart_readback", got_rd, 32'h363);

`ifdef APB_TIMEOUT_EN
    // pready stuck low: abort with error after TO ACCESS cycles
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h03; apb_pready = 0; apb_prdata = 32'h77;
    rsp_ready = 0;
    while (!cmd_ready) cyc();
    cyc();
    cmd_valid = 0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      chk("to_penable", 32'(apb_penable), 32'd1);
      cyc();
    end
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'd0);
    chk("to_psel", 32'(apb_psel), 32'd0);
    rsp_ready = 1;
    cyc();
    // pready on the last allowed cycle completes normally
    rsp_ready = 0; cmd_valid = 1;
    cyc();
    cmd_valid = 0;
    cyc();
    for (int k = 0; k < 8; k++) begin
      apb_pready = (k == 7); apb_prdata = 32'h55;
      cyc();
    end
    chk("to_edge_valid", 32'(rsp_valid), 32'd1);
    chk("to_edge_err", 32'(rsp_err), 32'd0);
    chk("to_edge_rdata", rsp_rdata, 32'h55);
    rsp_ready = 1; apb_pready = 0;
    cyc();
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned thr;
      thr = (i / 500) % 3 == 0 ? 9 : ((i / 500) % 3 == 1 ? 6 : 3);
      cmd_valid   = ($urandom_range(0, 1) == 1);
      cmd_write   = ($urandom_range(0, 1) == 1);
      cmd_addr    = AW'($urandom);
      cmd_wdata   = $urandom;
      rsp_ready   = ($urandom_range(0, 9) < 6);
      apb_pready  = ($urandom_range(0, 9) < thr);
      apb_prdata  = $urandom;
      apb_pslverr = ($urandom_range(0, 3) == 0);
      if (i % 997 == 500) begin
        rst = 1;
        cyc();
        rst = 0;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
